param_shift_register: RTL and testbench

- Parametrised WIDTH-bit, DEPTH-stage delay line.
- Generalises the fixed 8-bit, 5-stage shift chain.
- Adds:
  - clock enable
  - mode control: hold, shift, parallel load, synchronous clear
  - selectable tap readout
  - fill tracking, so downstream logic knows when the output stage holds real data
- Sits in datapaths as a configurable pipeline delay or sample window.

---
 rtl/shift_pkg.sv | 11 +
 rtl/sat_fill_counter.sv | 45 ++++
 rtl/param_shift_register.sv | 78 +++++++
 tb/tb_param_shift_register.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encoding shared by the parametrised shift register slice
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_e;

endpackage

// File: rtl/sat_fill_counter.sv
// rtl/sat_fill_counter.sv - saturating occupancy counter with load-to-max and clear
module sat_fill_counter #(
  parameter  int MAX = 5,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          inc,
  input  logic          set_max,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_d, count_q;
  logic          at_max_d, at_max_q;

  // Compare before adding so the count can never wrap past MAX at CW bits.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clr)                          count_d = '0;
      else if (set_max)                 count_d = MAX_C;
      else if (inc && count_q != MAX_C) count_d = count_q + CW'(1);
    end
    at_max_d = (count_d == MAX_C);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      at_max_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      at_max_q <= at_max_d;
    end
  end

  assign count  = count_q;
  assign at_max = at_max_q;

endmodule

// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - WIDTH x DEPTH delay line with enable, modes, tap readout and fill tracking
module param_shift_register
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 5,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [SW-1:0]          tap_sel,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       tap_out,
  output logic [CW-1:0]          fill_count,
  output logic                   full
);

  mode_e            mode_s;
  logic [WIDTH-1:0] stage [DEPTH];

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d, stage_q, shift_in;

    if (i == DEPTH - 1) begin : g_input_end
      assign shift_in = din;
    end else begin : g_inner
      assign shift_in = stage[i+1];
    end

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        case (mode_s)
          MODE_SHIFT: stage_d = shift_in;
          MODE_LOAD:  stage_d = load_data[i*WIDTH +: WIDTH];
          MODE_CLEAR: stage_d = '0;
          default:    stage_d = stage_q;
        endcase
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) stage_q <= '0;
      else        stage_q <= stage_d;
    end

    assign stage[i] = stage_q;
  end

  // Indices at or beyond DEPTH match nothing and read back as zero.
  always_comb begin
    tap_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == SW'(k)) tap_out = stage[k];
    end
  end

  sat_fill_counter #(.MAX(DEPTH)) u_fill (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .inc     (mode_s == MODE_SHIFT),
    .set_max (mode_s == MODE_LOAD),
    .clr     (mode_s == MODE_CLEAR),
    .count   (fill_count),
    .at_max  (full)
  );

  assign dout = stage[0];

endmodule

// File: tb/tb_param_shift_register.sv
// tb/tb_param_shift_register.sv - scoreboard bench for param_shift_register at 8x5, 1x2 and 16x8
module tb_param_shift_register;

  logic         clock;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [15:0]  din16;
  logic [39:0]  ld0;
  logic [1:0]   ld1;
  logic [127:0] ld2;
  logic [2:0]   tap0;
  logic [0:0]   tap1;
  logic [2:0]   tap2;
  logic [7:0]   dout0, tapo0;
  logic [0:0]   dout1, tapo1;
  logic [15:0]  dout2, tapo2;
  logic [2:0]   fill0;
  logic [1:0]   fill1;
  logic [3:0]   fill2;
  logic         full0, full1, full2;

  param_shift_register #(.WIDTH(8), .DEPTH(5)) dut0 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .din(din16[7:0]),
    .load_data(ld0), .tap_sel(tap0), .dout(dout0), .tap_out(tapo0),
    .fill_count(fill0), .full(full0));

  param_shift_register #(.WIDTH(1), .DEPTH(2)) dut1 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .din(din16[0:0]),
    .load_data(ld1), .tap_sel(tap1), .dout(dout1), .tap_out(tapo1),
    .fill_count(fill1), .full(full1));

  param_shift_register #(.WIDTH(16), .DEPTH(8)) dut2 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .din(din16),
    .load_data(ld2), .tap_sel(tap2), .dout(dout2), .tap_out(tapo2),
    .fill_count(fill2), .full(full2));

  localparam logic [1:0] HOLD = 2'd0, SHIFT = 2'd1, LOAD = 2'd2, CLEAR = 2'd3;

  typedef struct {
    string       name;
    int          dut;
    logic [15:0] dout;
    logic [15:0] tap;
    int          fill;
    bit          full;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Monitor: outputs are settled one unit after a falling clock edge or a reset assertion.
  always @(negedge clock or negedge reset) begin
    exp_t        e;
    logic [15:0] a_dout, a_tap;
    int          a_fill;
    bit          a_full;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin a_dout = {8'h0, dout0};  a_tap = {8'h0, tapo0};  a_fill = int'(fill0); a_full = full0; end
        1:       begin a_dout = {15'h0, dout1}; a_tap = {15'h0, tapo1}; a_fill = int'(fill1); a_full = full1; end
        default: begin a_dout = dout2;          a_tap = tapo2;          a_fill = int'(fill2); a_full = full2; end
      endcase
      n_compared++;
      if (a_dout !== e.dout || a_tap !== e.tap || a_fill != e.fill || a_full !== e.full) begin
        n_mismatched++;
        $display("FAIL %s: got dout=%h tap=%h fill=%0d full=%0b, expected dout=%h tap=%h fill=%0d full=%0b",
                 e.name, a_dout, a_tap, a_fill, a_full, e.dout, e.tap, e.fill, e.full);
      end
    end
  end

  task automatic expect_out(input int dut, input string nm, input logic [15:0] d,
                            input logic [15:0] t, input int f, input bit fl);
    exp_t e;
    e.name = nm; e.dut = dut; e.dout = d; e.tap = t; e.fill = f; e.full = fl;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit e, input logic [1:0] m, input logic [15:0] d);
    en = e; mode = m; din16 = d;
    @(posedge clock);
    #1;
  endtask

  logic [7:0]  main_words [6];
  logic [7:0]  hold_din   [3];
  logic [2:0]  hold_tap   [3];
  logic [7:0]  hold_exp   [3];
  logic [15:0] sweep_words [10];

  initial begin
    main_words  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    hold_din    = '{8'h00, 8'hFF, 8'h5A};
    hold_tap    = '{3'd4, 3'd2, 3'd1};
    hold_exp    = '{8'hF6, 8'hD4, 8'hC3};
    sweep_words = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001, 16'hFFFE,
                    16'h5555, 16'hAAAB, 16'h7F80, 16'h0101, 16'hC3C2};

    reset = 1'b1; en = 1'b0; mode = HOLD; din16 = '0;
    ld0 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; ld1 = '0; ld2 = '0;
    tap0 = 3'd4; tap1 = 1'b1; tap2 = 3'd7;
    #1;
    expect_out(0, "reset_state", 16'h0, 16'h0, 0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    // Delay latency: tap 4 shows the newest word, dout the oldest.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, SHIFT, {8'h0, main_words[k]});
      expect_out(0, $sformatf("latency_shift%0d", k),
                 (k == 4) ? 16'h00A1 : (k == 5) ? 16'h00B2 : 16'h0000,
                 {8'h0, main_words[k]}, (k < 5) ? k + 1 : 5, k >= 4);
    end

    for (int k = 0; k < 3; k++) begin
      step(1'b0, SHIFT, {8'h0, hold_din[k]});
      tap0 = hold_tap[k];
      expect_out(0, $sformatf("enable_hold%0d", k), 16'h00B2, {8'h0, hold_exp[k]}, 5, 1'b1);
    end

    step(1'b1, LOAD, 16'h0);
    for (int t = 0; t < 8; t++) begin
      step(1'b0, HOLD, 16'h0);
      tap0 = 3'(t);
      expect_out(0, $sformatf("load_tap%0d", t), 16'h0011,
                 (t < 5) ? 16'(8'h11 * (t + 1)) : 16'h0000, 5, 1'b1);
    end

    step(1'b1, CLEAR, 16'h0);
    tap0 = 3'd2;
    expect_out(0, "sync_clear", 16'h0, 16'h0, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, HOLD, 16'h00FF);
      expect_out(0, $sformatf("hold_after_clear%0d", k), 16'h0, 16'h0, 0, 1'b0);
    end

    step(1'b1, LOAD, 16'h0);
    tap0 = 3'd3;
    expect_out(0, "reload", 16'h0011, 16'h0044, 5, 1'b1);
    @(negedge clock);
    #2;
    expect_out(0, "async_reset_flush", 16'h0, 16'h0, 0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    // Parameter sweep: both sweep instances were just flushed by reset.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, SHIFT, sweep_words[k]);
      expect_out(1, $sformatf("w1d2_shift%0d", k),
                 (k >= 1) ? {15'h0, sweep_words[k-1][0]} : 16'h0,
                 {15'h0, sweep_words[k][0]}, (k < 2) ? k + 1 : 2, k >= 1);
      expect_out(2, $sformatf("w16d8_shift%0d", k),
                 (k >= 7) ? sweep_words[k-7] : 16'h0,
                 sweep_words[k], (k < 8) ? k + 1 : 8, k >= 7);
    end

    step(1'b0, HOLD, 16'h0);
    repeat (3) @(negedge clock);
    #3;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
